lap_recorder: RTL and testbench

LAP_RECORDER -- requirements
Module: lap_recorder

---
 rtl/lap_recorder.sv | 131 +++++++++++++
 tb/tb_lap_recorder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lap_recorder.sv
// Lap recorder for a stopwatch: captures the live counter into a small lap
// table on split, freezes the display on the captured value for a hold
// period, and lets the user browse stored laps while the stopwatch is stopped.
module lap_recorder #(
  parameter int TIME_W   = 16,
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 50_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     count_enabled,
  input  logic                     init_regs,
  input  logic                     split,
  input  logic                     recall,
  input  logic [TIME_W-1:0]        time_in,
  output logic [TIME_W-1:0]        lap_out,
  output logic [$clog2(DEPTH)-1:0] lap_idx,
  output logic                     freeze,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   lap_cnt
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  // HOLD_CYC-1 always fits in clog2(HOLD_CYC) bits; keep at least one bit
  // so HOLD_CYC=1 still elaborates.
  localparam int TMR_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [TMR_W-1:0] HOLD_LD   = TMR_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {REC, HOLD, BROWSE} state_t;

  state_t                          state, state_nxt;
  logic   [TMR_W-1:0]              tmr;
  logic   [DEPTH-1:0][TIME_W-1:0]  entry;

  // Per-edge actions, mutually exclusive, decoded in priority order.
  logic do_clr, do_cap, do_brw_start, do_brw_step;
  logic last_entry;
  logic [IDX_W-1:0] idx_inc;

  assign full       = (lap_cnt == DEPTH_CNT);
  assign idx_inc    = lap_idx + 1'b1;
  // Browsing sits on the newest stored lap; the next recall leaves BROWSE.
  assign last_entry = ({1'b0, lap_idx} == (lap_cnt - 1'b1));

  // State register; freeze is a flop tracking the registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= REC;
      freeze <= 1'b0;
    end else begin
      state  <= state_nxt;
      freeze <= (state_nxt != REC);
    end
  end

  // Next state and action decode: init_regs > capture > recall.
  always_comb begin
    state_nxt    = state;
    do_clr       = 1'b0;
    do_cap       = 1'b0;
    do_brw_start = 1'b0;
    do_brw_step  = 1'b0;
    if (init_regs) begin
      do_clr    = 1'b1;
      state_nxt = REC;
    end else if (split && count_enabled && !full && (state != BROWSE)) begin
      // Capture is legal from REC and also restarts an ongoing HOLD.
      do_cap    = 1'b1;
      state_nxt = HOLD;
    end else begin
      case (state)
        REC: begin
          if (recall && !count_enabled && (lap_cnt != '0)) begin
            do_brw_start = 1'b1;
            state_nxt    = BROWSE;
          end
        end
        HOLD: begin
          // Timer reaching zero marks the last frozen cycle.
          if (tmr == '0) state_nxt = REC;
        end
        BROWSE: begin
          // The stopwatch restarting overrides any pending browse step.
          if (count_enabled) begin
            state_nxt = REC;
          end else if (recall) begin
            if (last_entry) state_nxt = REC;
            else            do_brw_step = 1'b1;
          end
        end
        default: state_nxt = REC;
      endcase
    end
  end

  // Display value, index, lap count and hold timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      lap_cnt <= '0;
      lap_idx <= '0;
      lap_out <= '0;
      tmr     <= '0;
    end else if (do_clr) begin
      lap_cnt <= '0;
      lap_idx <= '0;
      lap_out <= '0;
      tmr     <= '0;
    end else if (do_cap) begin
      lap_out <= time_in;
      lap_idx <= lap_cnt[IDX_W-1:0];
      lap_cnt <= lap_cnt + 1'b1;
      tmr     <= HOLD_LD;
    end else if (do_brw_start) begin
      lap_idx <= '0;
      lap_out <= entry[0];
    end else if (do_brw_step) begin
      lap_idx <= idx_inc;
      lap_out <= entry[idx_inc];
    end else if ((state == HOLD) && (tmr != '0)) begin
      tmr <= tmr - 1'b1;
    end
  end

  // Lap table; contents are only meaningful below lap_cnt, so no reset.
  always_ff @(posedge clk) begin
    if (!reset && do_cap) entry[lap_cnt[IDX_W-1:0]] <= time_in;
  end

endmodule

// File: tb/tb_lap_recorder.sv
// Randomized + directed bench for lap_recorder (DEPTH=4, HOLD_CYC=4).
// The reference keeps laps in a queue and tracks the remaining frozen cycles
// and a browse flag; a negedge process compares every output every cycle.
module tb_lap_recorder;
  localparam int TIME_W = 16;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0, count_enabled = 1'b0, init_regs = 1'b0;
  logic              split = 1'b0, recall = 1'b0;
  logic [TIME_W-1:0] time_in = '0;
  logic [TIME_W-1:0] lap_out;
  logic [1:0]        lap_idx;
  logic              freeze, full;
  logic [2:0]        lap_cnt;

  lap_recorder #(.TIME_W(TIME_W), .DEPTH(DEPTH), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .reset(reset), .count_enabled(count_enabled),
    .init_regs(init_regs), .split(split), .recall(recall), .time_in(time_in),
    .lap_out(lap_out), .lap_idx(lap_idx), .freeze(freeze), .full(full),
    .lap_cnt(lap_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  // Reference state
  logic [TIME_W-1:0] laps[$];
  int                hold_left = 0;
  bit                brw = 1'b0;
  logic [TIME_W-1:0] m_out = '0;
  int                m_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    laps.delete();
    hold_left = 0;
    brw       = 1'b0;
    m_out     = '0;
    m_idx     = 0;
  endtask

  // What one clock edge does, given the inputs presented at that edge.
  task automatic model_step();
    if (reset || init_regs) begin
      model_clear();
    end else if (split && count_enabled && laps.size() < DEPTH && !brw) begin
      laps.push_back(time_in);
      m_out     = time_in;
      m_idx     = laps.size() - 1;
      hold_left = HOLD;
    end else if (brw) begin
      if (count_enabled) brw = 1'b0;
      else if (recall) begin
        if (m_idx == laps.size() - 1) brw = 1'b0;
        else begin
          m_idx++;
          m_out = laps[m_idx];
        end
      end
    end else if (hold_left > 0) begin
      hold_left--;
    end else if (recall && !count_enabled && laps.size() > 0) begin
      brw   = 1'b1;
      m_idx = 0;
      m_out = laps[0];
    end
  endtask

  // Continuous comparison against the reference.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("lap_out", 32'(lap_out), 32'(m_out));
      chk("lap_idx", 32'(lap_idx), 32'(m_idx));
      chk("lap_cnt", 32'(lap_cnt), 32'(laps.size()));
      chk("freeze",  32'(freeze),  32'(brw || hold_left > 0));
      chk("full",    32'(full),    32'(laps.size() == DEPTH));
    end
  end

  // Present inputs for one edge (called just after a negedge).
  task automatic tick(input logic rs, input logic in, input logic sp,
                      input logic rc, input logic [TIME_W-1:0] t);
    reset = rs; init_regs = in; split = sp; recall = rc; time_in = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    reset = 1'b0; init_regs = 1'b0; split = 1'b0; recall = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 16'h0);
  endtask

  initial begin
    @(negedge clk);
    tick(1, 0, 0, 0, 16'h0);
    tick(1, 0, 0, 0, 16'h0);
    chk_on = 1'b1;
    chk("rst_out", 32'(lap_out), 0);
    chk("rst_idx", 32'(lap_idx), 0);
    chk("rst_cnt", 32'(lap_cnt), 0);
    chk("rst_frz", 32'(freeze), 0);
    chk("rst_full", 32'(full), 0);

    // Single capture and hold length
    count_enabled = 1'b1;
    tick(0, 0, 1, 0, 16'h0123);
    chk("cap_frz", 32'(freeze), 1);
    chk("cap_out", 32'(lap_out), 32'h0123);
    chk("cap_idx", 32'(lap_idx), 0);
    chk("cap_cnt", 32'(lap_cnt), 1);
    idle(3);
    chk("hold_4th", 32'(freeze), 1);
    idle(1);
    chk("hold_end", 32'(freeze), 0);

    // Fill the table, fifth split ignored
    tick(0, 1, 0, 0, 16'h0);
    for (int v = 1; v <= 5; v++) begin
      tick(0, 0, 1, 0, 16'(v));
      if (v == 5) begin
        chk("full_frz", 32'(freeze), 0);
        chk("full_cnt", 32'(lap_cnt), 4);
        chk("full_flag", 32'(full), 1);
        chk("full_out", 32'(lap_out), 4);
      end
      idle(4);
    end

    // Browse all four laps, fifth recall leaves
    count_enabled = 1'b0;
    idle(1);
    for (int k = 0; k < 4; k++) begin
      tick(0, 0, 0, 1, 16'h0);
      chk("brw_out", 32'(lap_out), 32'(k + 1));
      chk("brw_idx", 32'(lap_idx), 32'(k));
      chk("brw_frz", 32'(freeze), 1);
      idle(1);
    end
    tick(0, 0, 0, 1, 16'h0);
    chk("brw_exit", 32'(freeze), 0);

    // init_regs while browsing
    tick(0, 0, 0, 1, 16'h0);
    chk("brw2_frz", 32'(freeze), 1);
    tick(0, 1, 0, 0, 16'h0);
    chk("clr_cnt", 32'(lap_cnt), 0);
    chk("clr_out", 32'(lap_out), 0);
    chk("clr_frz", 32'(freeze), 0);
    tick(0, 0, 0, 1, 16'h0);
    chk("clr_rcl", 32'(freeze), 0);

    // Re-capture during HOLD restarts the timer
    count_enabled = 1'b1;
    tick(0, 0, 1, 0, 16'h0010);
    idle(1);
    tick(0, 0, 1, 0, 16'h0020);
    chk("re_out", 32'(lap_out), 32'h0020);
    chk("re_idx", 32'(lap_idx), 1);
    idle(3);
    chk("re_hold", 32'(freeze), 1);
    idle(1);
    chk("re_end", 32'(freeze), 0);

    // split + recall together, then reset mid-HOLD
    tick(0, 1, 0, 0, 16'h0);
    tick(0, 0, 1, 1, 16'h0055);
    chk("sr_out", 32'(lap_out), 32'h0055);
    chk("sr_cnt", 32'(lap_cnt), 1);
    chk("sr_frz", 32'(freeze), 1);
    tick(1, 0, 1, 0, 16'h0077);
    chk("rh_out", 32'(lap_out), 0);
    chk("rh_cnt", 32'(lap_cnt), 0);
    chk("rh_frz", 32'(freeze), 0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) count_enabled = ~count_enabled;
      tick(logic'($urandom_range(0, 199) == 0),
           logic'($urandom_range(0, 39) == 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 2) == 0),
           16'($urandom_range(0, 16'hFFFF)));
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
